param_reserve_station: RTL and testbench

//  Parametrised arithmetic reservation station: buffers dispatched ops until both operands are ready, then issues one per cycle to the ALU.

---
 rtl/param_reserve_station_if.sv | 40 ++++
 rtl/param_reserve_station.sv | 242 ++++++++++++++++++++++++
 tb/tb_param_reserve_station.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_reserve_station_if.sv
// Dispatch / CDB / issue bundle for param_reserve_station.
// master = dispatcher + result producers + ALU side, slave = the station.
interface param_reserve_station_if #(
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 6,
   parameter int NUM_CDB  = 2
);
   logic                         in_valid;
   logic [OP_W-1:0]              in_op;
   logic [ROB_ID_W-1:0]          in_q1;
   logic [ROB_ID_W-1:0]          in_q2;
   logic [DATA_W-1:0]            in_v1;
   logic [DATA_W-1:0]            in_v2;
   logic [DATA_W-1:0]            in_pc;
   logic [DATA_W-1:0]            in_imm;
   logic [ROB_ID_W-1:0]          in_rob_id;
   logic [NUM_CDB-1:0]           cdb_valid;
   logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id;
   logic [NUM_CDB*DATA_W-1:0]    cdb_data;
   logic                         issue_valid;
   logic [OP_W-1:0]              issue_op;
   logic [DATA_W-1:0]            issue_v1;
   logic [DATA_W-1:0]            issue_v2;
   logic [DATA_W-1:0]            issue_pc;
   logic [DATA_W-1:0]            issue_imm;
   logic [ROB_ID_W-1:0]          issue_rob_id;

   modport master (
      output in_valid, in_op, in_q1, in_q2, in_v1, in_v2, in_pc, in_imm, in_rob_id,
      output cdb_valid, cdb_rob_id, cdb_data,
      input  issue_valid, issue_op, issue_v1, issue_v2, issue_pc, issue_imm, issue_rob_id
   );

   modport slave (
      input  in_valid, in_op, in_q1, in_q2, in_v1, in_v2, in_pc, in_imm, in_rob_id,
      input  cdb_valid, cdb_rob_id, cdb_data,
      output issue_valid, issue_op, issue_v1, issue_v2, issue_pc, issue_imm, issue_rob_id
   );
endinterface

// File: rtl/param_reserve_station.sv
// Parametrised arithmetic reservation station.
// Buffers dispatched ops until both source tags are resolved (tag 0 = ready),
// snoops NUM_CDB broadcast channels for wakeup (with bypass on insert) and
// issues one ready op per cycle through a registered issue bundle.
// Optional feature macro: RS_OLDEST_FIRST_EN -- oldest-ready issue via an age
// matrix; when undefined, the lowest-index ready entry issues.
module param_reserve_station #(
   parameter int RS_DEPTH = 16,
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 6,
   parameter int NUM_CDB  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy_i,
   input  logic                        flush_i,
   param_reserve_station_if.slave      rs_bus,
   output logic                        full_o,
   output logic [$clog2(RS_DEPTH):0]   count_o
);
   localparam int IDX_W = $clog2(RS_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [OP_W-1:0]     OPENUM_NOP = '0;
   localparam logic [ROB_ID_W-1:0] ZERO_ROB   = '0;

   typedef struct packed {
      logic [OP_W-1:0]     op;
      logic [ROB_ID_W-1:0] q1;
      logic [ROB_ID_W-1:0] q2;
      logic [DATA_W-1:0]   v1;
      logic [DATA_W-1:0]   v2;
      logic [DATA_W-1:0]   pc;
      logic [DATA_W-1:0]   imm;
      logic [ROB_ID_W-1:0] rob;
   } entry_t;

   typedef struct packed {
      logic [OP_W-1:0]     op;
      logic [DATA_W-1:0]   v1;
      logic [DATA_W-1:0]   v2;
      logic [DATA_W-1:0]   pc;
      logic [DATA_W-1:0]   imm;
      logic [ROB_ID_W-1:0] rob;
   } issue_t;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } snoop_t;

   entry_t              ent_q [RS_DEPTH];
   entry_t              ent_d [RS_DEPTH];
   logic [RS_DEPTH-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                iss_valid_q, iss_valid_d;
   issue_t              iss_q, iss_d;

   logic [RS_DEPTH-1:0] ready;
   logic [RS_DEPTH-1:0] cand;
   logic [IDX_W-1:0]    free_idx;
   logic [IDX_W-1:0]    sel_idx;
   logic                any_rdy;
   logic                full;
   logic                ins;

   // Tag match against all channels; the lowest-numbered matching channel wins.
   function automatic snoop_t snoop(input logic [ROB_ID_W-1:0]         tag,
                                    input logic [NUM_CDB-1:0]          vld,
                                    input logic [NUM_CDB*ROB_ID_W-1:0] ids,
                                    input logic [NUM_CDB*DATA_W-1:0]   data);
      snoop_t r;
      r = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
         if (tag != ZERO_ROB && vld[c] && ids[c*ROB_ID_W +: ROB_ID_W] == tag) begin
            r.hit  = 1'b1;
            r.data = data[c*DATA_W +: DATA_W];
         end
      end
      return r;
   endfunction

   assign full = &busy_q;
   assign ins  = rs_bus.in_valid && !full;

   // Readiness is taken from registered state only, so a fresh wakeup issues a cycle later.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         ready[i] = busy_q[i] && (ent_q[i].q1 == ZERO_ROB) && (ent_q[i].q2 == ZERO_ROB);
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   // old_q[i][j] set means slot j was inserted before slot i.
   logic [RS_DEPTH-1:0] old_q [RS_DEPTH];
   logic [RS_DEPTH-1:0] old_d [RS_DEPTH];

   // Age update on insert and oldest-ready candidate (no older ready entry).
   always_comb begin
      old_d = old_q;
      if (!flush_i && ins) begin
         old_d[free_idx] = busy_q;
         for (int i = 0; i < RS_DEPTH; i++) begin
            old_d[i][free_idx] = 1'b0;
         end
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         cand[i] = ready[i] && ((old_q[i] & ready) == '0);
      end
   end

   // Age matrix register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) old_q[i] <= '0;
      end else if (rdy_i) begin
         old_q <= old_d;
      end
   end
`else
   assign cand = ready;
`endif

   // Lowest free slot (pre-issue) and lowest-index issue candidate.
   always_comb begin
      logic found;
      free_idx = '0;
      found    = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!busy_q[i] && !found) begin
            found    = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
      sel_idx = '0;
      any_rdy = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (cand[i] && !any_rdy) begin
            any_rdy = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end

   // Next state: flush drops everything; otherwise issue, wakeup, then insert with bypass.
   always_comb begin
      snoop_t s;
      busy_d      = busy_q;
      ent_d       = ent_q;
      count_d     = count_q;
      iss_valid_d = iss_valid_q;
      iss_d       = iss_q;
      s           = '0;
      if (flush_i) begin
         busy_d      = '0;
         count_d     = '0;
         iss_valid_d = 1'b0;
         iss_d.op    = OPENUM_NOP;
      end else begin
         iss_valid_d = any_rdy;
         if (any_rdy) begin
            busy_d[sel_idx] = 1'b0;
            iss_d.op  = ent_q[sel_idx].op;
            iss_d.v1  = ent_q[sel_idx].v1;
            iss_d.v2  = ent_q[sel_idx].v2;
            iss_d.pc  = ent_q[sel_idx].pc;
            iss_d.imm = ent_q[sel_idx].imm;
            iss_d.rob = ent_q[sel_idx].rob;
         end else begin
            iss_d.op = OPENUM_NOP;
         end
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy_q[i]) begin
               s = snoop(ent_q[i].q1, rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_data);
               if (s.hit) begin
                  ent_d[i].q1 = ZERO_ROB;
                  ent_d[i].v1 = s.data;
               end
               s = snoop(ent_q[i].q2, rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_data);
               if (s.hit) begin
                  ent_d[i].q2 = ZERO_ROB;
                  ent_d[i].v2 = s.data;
               end
            end
         end
         if (ins) begin
            busy_d[free_idx]     = 1'b1;
            ent_d[free_idx].op   = rs_bus.in_op;
            ent_d[free_idx].q1   = rs_bus.in_q1;
            ent_d[free_idx].q2   = rs_bus.in_q2;
            ent_d[free_idx].v1   = rs_bus.in_v1;
            ent_d[free_idx].v2   = rs_bus.in_v2;
            ent_d[free_idx].pc   = rs_bus.in_pc;
            ent_d[free_idx].imm  = rs_bus.in_imm;
            ent_d[free_idx].rob  = rs_bus.in_rob_id;
            s = snoop(rs_bus.in_q1, rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_data);
            if (s.hit) begin
               ent_d[free_idx].q1 = ZERO_ROB;
               ent_d[free_idx].v1 = s.data;
            end
            s = snoop(rs_bus.in_q2, rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_data);
            if (s.hit) begin
               ent_d[free_idx].q2 = ZERO_ROB;
               ent_d[free_idx].v2 = s.data;
            end
         end
         count_d = count_q + CNT_W'(ins) - CNT_W'(any_rdy);
      end
   end

   // Control and issue registers: reset, then frozen while rdy_i is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= '0;
         count_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_q       <= '0;
      end else if (rdy_i) begin
         busy_q      <= busy_d;
         count_q     <= count_d;
         iss_valid_q <= iss_valid_d;
         iss_q       <= iss_d;
      end
   end

   // Entry payload storage; only meaningful where busy_q is set.
   always_ff @(posedge clk) begin
      if (rdy_i) begin
         ent_q <= ent_d;
      end
   end

   assign full_o              = full;
   assign count_o             = count_q;
   assign rs_bus.issue_valid  = iss_valid_q;
   assign rs_bus.issue_op     = iss_q.op;
   assign rs_bus.issue_v1     = iss_q.v1;
   assign rs_bus.issue_v2     = iss_q.v2;
   assign rs_bus.issue_pc     = iss_q.pc;
   assign rs_bus.issue_imm    = iss_q.imm;
   assign rs_bus.issue_rob_id = iss_q.rob;
endmodule

// File: tb/tb_param_reserve_station.sv
// Scoreboard bench for param_reserve_station: a queue-based reference model
// predicts each issue bundle; a monitor pops and compares on every fresh issue.
module tb_param_reserve_station;
   localparam int RS_DEPTH = 16;
   localparam int ROB_ID_W = 4;
   localparam int DATA_W   = 32;
   localparam int OP_W     = 6;
   localparam int NUM_CDB  = 2;
   localparam int CNT_W    = $clog2(RS_DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rdy = 1'b1;
   logic             flush = 1'b0;
   logic             full;
   logic [CNT_W-1:0] count;

   param_reserve_station_if #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

   param_reserve_station #(.RS_DEPTH(RS_DEPTH), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W),
                           .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .rst(rst), .rdy_i(rdy), .flush_i(flush),
      .rs_bus(bus), .full_o(full), .count_o(count));

   always #5 clk = ~clk;

   typedef struct {
      logic [OP_W-1:0]     op;
      logic [DATA_W-1:0]   v1, v2, pc, imm;
      logic [ROB_ID_W-1:0] rob;
   } bundle_t;

   int checks = 0;
   int errors = 0;

   // Reference model: a bag of waiting ops with insertion ages.
   bundle_t             exp_q[$];
   bundle_t             mlast;
   bit                  mvalid;
   int                  mcount;
   int                  seq;
   bit                  mbusy [RS_DEPTH];
   int                  mage  [RS_DEPTH];
   logic [ROB_ID_W-1:0] mq1   [RS_DEPTH];
   logic [ROB_ID_W-1:0] mq2   [RS_DEPTH];
   bundle_t             ment  [RS_DEPTH];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   task automatic cdb_lookup(input logic [ROB_ID_W-1:0] tag, output bit hit, output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (tag == 0) return;
      for (int c = 0; c < NUM_CDB; c++) begin
         if (bus.cdb_valid[c] && bus.cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == tag) begin
            hit = 1'b1;
            d   = bus.cdb_data[c*DATA_W +: DATA_W];
            break;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < RS_DEPTH; i++) mbusy[i] = 1'b0;
      mcount = 0;
      mvalid = 1'b0;
      mlast  = '{op: '0, v1: '0, v2: '0, pc: '0, imm: '0, rob: '0};
      seq    = 0;
   endtask

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_step();
      int                fr, sel;
      bit                hit;
      logic [DATA_W-1:0] d;
      if (!rdy) return;
      if (flush) begin
         for (int i = 0; i < RS_DEPTH; i++) mbusy[i] = 1'b0;
         mcount   = 0;
         mvalid   = 1'b0;
         mlast.op = '0;
         return;
      end
      fr = -1;
      for (int i = 0; i < RS_DEPTH; i++) if (!mbusy[i] && fr < 0) fr = i;
      sel = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (mbusy[i] && mq1[i] == 0 && mq2[i] == 0) begin
`ifdef RS_OLDEST_FIRST_EN
            if (sel < 0 || mage[i] < mage[sel]) sel = i;
`else
            if (sel < 0) sel = i;
`endif
         end
      end
      if (sel >= 0) begin
         exp_q.push_back(ment[sel]);
         mlast      = ment[sel];
         mvalid     = 1'b1;
         mbusy[sel] = 1'b0;
         mcount--;
      end else begin
         mvalid   = 1'b0;
         mlast.op = '0;
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (mbusy[i]) begin
            cdb_lookup(mq1[i], hit, d);
            if (hit) begin mq1[i] = '0; ment[i].v1 = d; end
            cdb_lookup(mq2[i], hit, d);
            if (hit) begin mq2[i] = '0; ment[i].v2 = d; end
         end
      end
      if (bus.in_valid && fr >= 0) begin
         mbusy[fr] = 1'b1;
         mage[fr]  = seq++;
         mq1[fr]   = bus.in_q1;
         mq2[fr]   = bus.in_q2;
         ment[fr]  = '{op: bus.in_op, v1: bus.in_v1, v2: bus.in_v2, pc: bus.in_pc,
                       imm: bus.in_imm, rob: bus.in_rob_id};
         cdb_lookup(bus.in_q1, hit, d);
         if (hit) begin mq1[fr] = '0; ment[fr].v1 = d; end
         cdb_lookup(bus.in_q2, hit, d);
         if (hit) begin mq2[fr] = '0; ment[fr].v2 = d; end
         mcount++;
      end
   endtask

   task automatic clear_in();
      bus.in_valid  = 1'b0;
      bus.cdb_valid = '0;
   endtask

   task automatic insert(input logic [OP_W-1:0] op, input logic [ROB_ID_W-1:0] q1, input logic [ROB_ID_W-1:0] q2,
                         input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2, input logic [ROB_ID_W-1:0] rob);
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_q1     = q1;
      bus.in_q2     = q2;
      bus.in_v1     = v1;
      bus.in_v2     = v2;
      bus.in_pc     = $urandom;
      bus.in_imm    = $urandom;
      bus.in_rob_id = rob;
   endtask

   task automatic set_cdb(input int c, input logic [ROB_ID_W-1:0] tag, input logic [DATA_W-1:0] data);
      bus.cdb_valid[c] = 1'b1;
      bus.cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] = tag;
      bus.cdb_data[c*DATA_W +: DATA_W] = data;
   endtask

   // One clock: model prediction, edge, then per-cycle status checks.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      clear_in();
      chk("count", count, mcount);
      chk("full", full, (mcount == RS_DEPTH));
      chk("issue_valid", bus.issue_valid, mvalid);
      if (!mvalid) chk("issue_op_nop", bus.issue_op, 0);
      chk("issue_rob_hold", bus.issue_rob_id, mlast.rob);
   endtask

   // Monitor: every fresh issue bundle is popped from the scoreboard and compared.
   initial begin
      bit      live;
      bundle_t e;
      forever begin
         @(posedge clk);
         live = rdy && !rst;
         @(negedge clk);
         if (live && bus.issue_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL issue_unexpected actual=rob%0h required=none", bus.issue_rob_id);
            end else begin
               e = exp_q.pop_front();
               chk("sb_op", bus.issue_op, e.op);
               chk("sb_v1", bus.issue_v1, e.v1);
               chk("sb_v2", bus.issue_v2, e.v2);
               chk("sb_pc", bus.issue_pc, e.pc);
               chk("sb_imm", bus.issue_imm, e.imm);
               chk("sb_rob", bus.issue_rob_id, e.rob);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_q1 = '0; bus.in_q2 = '0;
      bus.in_v1 = '0; bus.in_v2 = '0; bus.in_pc = '0; bus.in_imm = '0; bus.in_rob_id = '0;
      bus.cdb_valid = '0; bus.cdb_rob_id = '0; bus.cdb_data = '0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_valid", bus.issue_valid, 0);
      chk("rst_op", bus.issue_op, 0);
      chk("rst_v1", bus.issue_v1, 0);
      chk("rst_v2", bus.issue_v2, 0);
      chk("rst_pc", bus.issue_pc, 0);
      chk("rst_imm", bus.issue_imm, 0);
      chk("rst_rob", bus.issue_rob_id, 0);
      rst = 1'b0;

      // Ready op issues one cycle after insert.
      insert(6'd1, 0, 0, 32'd5, 32'd7, 4'd3); tick();
      tick();
      chk("t1_valid", bus.issue_valid, 1);
      chk("t1_v1", bus.issue_v1, 32'd5);
      chk("t1_v2", bus.issue_v2, 32'd7);
      chk("t1_rob", bus.issue_rob_id, 4'd3);
      chk("t1_count", count, 0);

      // Wakeup on channel 1.
      insert(6'd2, 4'd4, 0, 32'h0, 32'h1, 4'd5); tick();
      set_cdb(1, 4'd4, 32'h55); tick();
      tick();
      chk("t2_v1", bus.issue_v1, 32'h55);

      // Insert-time bypass on channel 0.
      insert(6'd3, 0, 4'd6, 32'h2, 32'h0, 4'd7); set_cdb(0, 4'd6, 32'd9); tick();
      tick();
      chk("t3_v2", bus.issue_v2, 32'd9);
      tick();

      // Fill, overflow drop, then drain one per cycle.
      for (int i = 0; i < RS_DEPTH; i++) begin
         insert(6'(i + 1), 4'd2, 0, 32'(i), 32'(i * 3), 4'(i)); tick();
      end
      chk("fill_full", full, 1);
      insert(6'd9, 0, 0, 32'hdead, 32'hbeef, 4'd15); tick();
      chk("fill_drop_count", count, RS_DEPTH);
      set_cdb(0, 4'd2, 32'h2222); tick();
      for (int i = 0; i < RS_DEPTH + 1; i++) tick();
      chk("drain_count", count, 0);

      // Age ordering: B (older, slot1) vs C (younger, slot0).
      insert(6'd4, 4'd5, 0, 32'h0, 32'h0, 4'd1); tick();
      insert(6'd5, 4'd6, 0, 32'h0, 32'h0, 4'd2); tick();
      set_cdb(0, 4'd5, 32'h11); tick();
      tick();
      insert(6'd6, 0, 0, 32'h33, 32'h44, 4'd3); set_cdb(1, 4'd6, 32'h22); tick();
      tick();
`ifdef RS_OLDEST_FIRST_EN
      chk("age_first", bus.issue_rob_id, 4'd2);
`else
      chk("age_first", bus.issue_rob_id, 4'd3);
`endif
      tick();
      tick();

      // Flush with five waiting entries and a concurrent insert.
      for (int i = 0; i < 5; i++) begin
         insert(6'd7, 4'd9, 0, 32'(i), 32'(i), 4'(i + 8)); tick();
      end
      flush = 1'b1; insert(6'd7, 0, 0, 32'h1, 32'h1, 4'd13); tick();
      flush = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_full", full, 0);
      chk("flush_valid", bus.issue_valid, 0);
      tick();

      // Freeze: rdy low holds the issue bundle and drops inputs.
      insert(6'd8, 0, 0, 32'hAB, 32'hCD, 4'd11); tick();
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         insert(6'd9, 0, 0, 32'h1, 32'h2, 4'd12); set_cdb(0, 4'd9, 32'h9); tick();
         chk("frz_valid", bus.issue_valid, 1);
         chk("frz_v1", bus.issue_v1, 32'hAB);
         chk("frz_count", count, 0);
      end
      rdy = 1'b1;
      tick();
      chk("unfrz_valid", bus.issue_valid, 0);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         rdy   = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1) == 1)
            insert(6'($urandom_range(1, 63)),
                   ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                   ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                   $urandom, $urandom, 4'($urandom_range(0, 15)));
         for (int c = 0; c < NUM_CDB; c++)
            if ($urandom_range(0, 1) == 1) set_cdb(c, 4'($urandom_range(1, 7)), $urandom);
         tick();
      end
      rdy = 1'b1; flush = 1'b1; tick();
      flush = 1'b0; tick();
      tick();
      chk("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
